// File: rtl/mkgauss_poly.sv
// Gaussian polynomial sampler for key generation: folds 2^(10-logn) table samples per
// coefficient, streams n = 2^logn coefficients and accumulates their squared norm.
module mkgauss_poly #(
    parameter int LOGN_MAX = 10,
    parameter int VAL_W    = 16,
    parameter int NORM_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        logn_in,
    input  logic              rng_valid,
    input  logic [127:0]      rng,
    output logic              rng_extract,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [VAL_W-1:0]  coef,
    output logic [9:0]        coef_idx,
    output logic [NORM_W-1:0] sqnorm,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Cumulative distribution thresholds scaled by 2^63; entry 0 is the zero threshold.
    localparam logic [62:0] GAUSS_TAB [0:26] = '{
        63'd1283868770400643928, 63'd6416574995475331444, 63'd4078260278032692663,
        63'd2353523259288686585, 63'd1227179971273316331, 63'd575931623374121527,
        63'd242543240509105209,  63'd91437049221049666,   63'd30799446349977173,
        63'd9255276791179340,    63'd2478152334826140,    63'd590642893610164,
        63'd125206034929641,     63'd23590435911403,      63'd3948334035941,
        63'd586753615614,        63'd77391054539,         63'd9056793210,
        63'd940121950,           63'd86539696,            63'd7062824,
        63'd510971,              63'd32764,               63'd1862,
        63'd94,                  63'd4,                   63'd0
    };

    state_t                    state_reg, state_next;
    logic [3:0]                logn_reg, logn_next;
    logic signed [VAL_W-1:0]   acc_reg, acc_next;
    logic [9:0]                cnt_reg, cnt_next;
    logic [9:0]                idx_reg, idx_next;
    logic signed [VAL_W-1:0]   coef_reg, coef_next;
    logic [NORM_W-1:0]         sqnorm_reg, sqnorm_next;
    logic                      err_reg, err_next;

    logic [62:0]               r1_low;
    logic [62:0]               r2_low;
    logic                      r1_neg;
    logic                      unused_rng_msb;
    logic                      is_zero;
    logic [25:0]               mag_hit;
    logic [4:0]                mag;
    logic signed [VAL_W-1:0]   mag_ext;
    logic signed [VAL_W-1:0]   samp_val;

    logic [10:0]               fold_len;
    logic [9:0]                fold_last;
    logic [10:0]               n_len;
    logic [9:0]                n_last;
    logic                      logn_ok;
    logic signed [2*VAL_W-1:0] coef_sq;
    logic [NORM_W-1:0]         sq_ext;

    assign r1_neg         = rng[63];
    assign r1_low         = rng[62:0];
    assign r2_low         = rng[126:64];
    // Bit 127 carries no information for the magnitude draw.
    assign unused_rng_msb = rng[127];

    assign is_zero = (r1_low < GAUSS_TAB[0]);

    genvar gi;
    generate
        for (gi = 1; gi <= 26; gi++) begin : g_mag_cmp
            assign mag_hit[gi-1] = (r2_low < GAUSS_TAB[gi]);
        end
    endgenerate

    always_comb begin
        mag = 5'd1;
        for (int k = 0; k < 26; k++) begin
            mag = mag + {4'd0, mag_hit[k]};
        end
    end

    assign mag_ext = VAL_W'(mag);

    always_comb begin
        samp_val = '0;
        if (!is_zero) begin
            samp_val = r1_neg ? -mag_ext : mag_ext;
        end
    end

    // Fold length and polynomial length both derive from the latched degree.
    assign fold_len  = 11'd1 << (4'd10 - logn_reg);
    assign fold_last = 10'(fold_len - 11'd1);
    assign n_len     = 11'd1 << logn_reg;
    assign n_last    = 10'(n_len - 11'd1);
    assign logn_ok   = (logn_in != 4'd0) && (logn_in <= 4'(LOGN_MAX));

    assign coef_sq = (2*VAL_W)'(coef_reg) * (2*VAL_W)'(coef_reg);
    assign sq_ext  = NORM_W'($unsigned(coef_sq));

    always_comb begin
        state_next  = state_reg;
        logn_next   = logn_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        coef_next   = coef_reg;
        sqnorm_next = sqnorm_reg;
        err_next    = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (logn_ok) begin
                            logn_next   = logn_in;
                            acc_next    = '0;
                            cnt_next    = '0;
                            idx_next    = '0;
                            sqnorm_next = '0;
                            state_next  = ACC;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (rng_valid) begin
                        if (cnt_reg == fold_last) begin
                            coef_next  = acc_reg + samp_val;
                            acc_next   = '0;
                            cnt_next   = '0;
                            state_next = OUT;
                        end else begin
                            acc_next = acc_reg + samp_val;
                            cnt_next = cnt_reg + 10'd1;
                        end
                    end
                end
                OUT: begin
                    if (coef_ready) begin
                        sqnorm_next = sqnorm_reg + sq_ext;
                        if (idx_reg == n_last) begin
                            state_next = FIN;
                        end else begin
                            idx_next   = idx_reg + 10'd1;
                            state_next = ACC;
                        end
                    end
                end
                FIN: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            logn_reg   <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            coef_reg   <= '0;
            sqnorm_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            logn_reg   <= logn_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            coef_reg   <= coef_next;
            sqnorm_reg <= sqnorm_next;
            err_reg    <= err_next;
        end
    end

    assign rng_extract = (state_reg == ACC);
    assign coef_valid  = (state_reg == OUT);
    assign coef        = coef_reg;
    assign coef_idx    = idx_reg;
    assign sqnorm      = sqnorm_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == FIN);
    assign err         = err_reg;

endmodule

// File: tb/tb_mkgauss_poly.sv
// Scoreboard bench for mkgauss_poly: hand-derived per-word samples feed an expected queue,
// transferred coefficients are queued and compared per scenario.
module tb_mkgauss_poly;

    localparam int VAL_W  = 16;
    localparam int NORM_W = 32;

    localparam logic [62:0] T0 = 63'd1283868770400643928;
    localparam logic [62:0] T1 = 63'd6416574995475331444;
    localparam logic [62:0] T5 = 63'd575931623374121527;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [3:0]        logn_in = 4'd0;
    logic              rng_valid = 1'b0;
    logic [127:0]      rng = '0;
    logic              coef_ready = 1'b0;
    logic              rng_extract;
    logic              coef_valid;
    logic [VAL_W-1:0]  coef;
    logic [9:0]        coef_idx;
    logic [NORM_W-1:0] sqnorm;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    mkgauss_poly #(.LOGN_MAX(10), .VAL_W(VAL_W), .NORM_W(NORM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .logn_in(logn_in),
        .rng_valid(rng_valid), .rng(rng), .rng_extract(rng_extract),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef(coef), .coef_idx(coef_idx),
        .sqnorm(sqnorm), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int val;
        int idx;
    } xfer_t;

    int    tests_run = 0;
    int    tests_failed = 0;
    xfer_t exp_q[$];
    xfer_t obs_q[$];
    int    words_taken;
    int    done_cnt;
    int    stall_bad;
    int    stall_cycles;
    bit    timed_out;

    // Word patterns with their sample values worked out by hand from the threshold table.
    task automatic pick_word(input int mode, input int wc, output logic [127:0] w, output int s);
        int sel;
        sel = (mode == 2) ? ((wc < 512) ? 1 : 0) : mode;
        if (sel == 1 && (mode == 2 || wc % 2 == 0)) begin
            w = {64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF}; s = 1;
        end else if (sel == 1) begin
            w = {64'h0123_4567_89AB_CDEF, 64'h0}; s = 0;
        end else if (sel == 0) begin
            w = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; s = -26;
        end else begin
            case (wc % 8)
                0: begin w = {1'b0, T5, 1'b0, T0}; s = 5; end
                1: begin w = {1'b0, T5 - 63'd1, 1'b0, T0}; s = 6; end
                2: begin w = {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, T0 - 63'd1}; s = 0; end
                3: begin w = {64'd4, 1'b1, T0}; s = -25; end
                4: begin w = {64'd3, 1'b1, T0}; s = -26; end
                5: begin w = {1'b0, T1, 64'h7FFF_FFFF_FFFF_FFFF}; s = 1; end
                6: begin w = {1'b0, T1 - 63'd1, 64'h7FFF_FFFF_FFFF_FFFF}; s = 2; end
                default: begin w = {1'b1, T1 - 63'd1, 64'hFFFF_FFFF_FFFF_FFFF}; s = -2; end
            endcase
        end
    endtask

    task automatic drive_run(input int logn, input int mode, input int valid_pct,
                             input int stall_idx, input int abort_idx, input int budget);
        int g, wc, acc, in_coef, coef_no, stall_left, tail, s;
        bit stall_done, aborted, fin;
        logic [127:0] w;
        logic [VAL_W-1:0] hold_coef;
        logic [9:0] hold_idx;
        xfer_t x;
        g = 1 << (10 - logn);
        wc = 0; acc = 0; in_coef = 0; coef_no = 0; stall_left = 0; tail = 0;
        stall_done = 0; aborted = 0; fin = 0; hold_coef = '0; hold_idx = '0;
        exp_q.delete(); obs_q.delete();
        words_taken = 0; done_cnt = 0; stall_bad = 0; stall_cycles = 0; timed_out = 0;
        @(negedge clk); start = 1'b1; logn_in = 4'(logn); abort = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            pick_word(mode, wc, w, s);
            rng = w;
            rng_valid = ($urandom_range(99) < valid_pct);
            coef_ready = 1'b1;
            abort = 1'b0;
            #1;
            if (coef_valid && stall_idx >= 0 && !stall_done && coef_idx == 10'(stall_idx)) begin
                stall_done = 1; stall_left = 5; hold_coef = coef; hold_idx = coef_idx;
            end
            if (stall_left > 0) begin
                coef_ready = 1'b0; rng_valid = 1'b1; stall_cycles++;
                if (coef !== hold_coef || coef_idx !== hold_idx || coef_valid !== 1'b1 || rng_extract !== 1'b0)
                    stall_bad++;
                stall_left--;
            end
            if (abort_idx >= 0 && !aborted && coef_valid && coef_idx == 10'(abort_idx)) begin
                abort = 1'b1; coef_ready = 1'b0; aborted = 1;
            end
            #1;
            if (rng_valid && rng_extract) begin
                words_taken++; wc++; acc += s; in_coef++;
                if (in_coef == g) begin
                    x.val = acc; x.idx = coef_no; exp_q.push_back(x);
                    coef_no++; acc = 0; in_coef = 0;
                end
            end
            if (coef_valid && coef_ready) begin
                x.val = int'($signed(coef)); x.idx = int'(coef_idx); obs_q.push_back(x);
            end
            if (done) begin done_cnt++; fin = 1; end
            @(negedge clk);
            abort = 1'b0;
            if (aborted) break;
            if (fin) begin tail++; if (tail > 3) break; end
        end
        if (!aborted && !fin) timed_out = 1;
        rng_valid = 1'b0; coef_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, coef_valid, rng_extract, done, err} !== 5'b0 || coef !== '0 || coef_idx !== '0 || sqnorm !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b cv=%b ext=%b done=%b err=%b coef=%0d idx=%0d sq=%0d, want all 0",
                     busy, coef_valid, rng_extract, done, err, coef, coef_idx, sqnorm);
        end else $display("[TB] reset outputs all zero");
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, coef_valid, rng_extract, done, err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got flags %b, want 00000", {busy, coef_valid, rng_extract, done, err});
        end else $display("[TB] idle after reset release");
    endtask

    task automatic test_full_run();
        drive_run(10, 0, 100, -1, -1, 3000);
        tests_run++;
        if (timed_out !== 1'b0 || obs_q.size() !== 1024) begin
            tests_failed++; $display("FAIL t1_count: got %0d coefs timeout=%0b, want 1024 timeout=0", obs_q.size(), timed_out);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            xfer_t e;
            e.val = 99999; e.idx = -1;
            if (i < exp_q.size()) e = exp_q[i];
            tests_run++;
            if (obs_q[i].val !== e.val || obs_q[i].idx !== e.idx || e.val !== -26) begin
                tests_failed++; $display("FAIL t1_coef[%0d]: got %0d@%0d, want %0d@%0d (-26)", i, obs_q[i].val, obs_q[i].idx, e.val, e.idx);
            end else $display("[TB] t1 xfer %0d coef=%0d idx=%0d", i, obs_q[i].val, obs_q[i].idx);
        end
        tests_run++;
        if (sqnorm !== 32'd692224 || done_cnt !== 1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL t1_final: got sqnorm=%0d done=%0d busy=%b, want 692224 1 0", sqnorm, done_cnt, busy);
        end else $display("[TB] t1 sqnorm=%0d done pulses=%0d", sqnorm, done_cnt);
    endtask

    task automatic test_alt_pattern();
        drive_run(9, 1, 100, -1, -1, 2500);
        tests_run++;
        if (timed_out !== 1'b0 || obs_q.size() !== 512) begin
            tests_failed++; $display("FAIL t2_count: got %0d coefs timeout=%0b, want 512 timeout=0", obs_q.size(), timed_out);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            xfer_t e;
            e.val = 99999; e.idx = -1;
            if (i < exp_q.size()) e = exp_q[i];
            tests_run++;
            if (obs_q[i].val !== e.val || obs_q[i].idx !== e.idx || e.val !== 1) begin
                tests_failed++; $display("FAIL t2_coef[%0d]: got %0d@%0d, want %0d@%0d (+1)", i, obs_q[i].val, obs_q[i].idx, e.val, e.idx);
            end else $display("[TB] t2 xfer %0d coef=%0d idx=%0d", i, obs_q[i].val, obs_q[i].idx);
        end
        tests_run++;
        if (sqnorm !== 32'd512 || done_cnt !== 1) begin
            tests_failed++; $display("FAIL t2_final: got sqnorm=%0d done=%0d, want 512 1", sqnorm, done_cnt);
        end else $display("[TB] t2 sqnorm=%0d", sqnorm);
    endtask

    task automatic test_backpressure();
        drive_run(10, 0, 100, 7, -1, 3000);
        tests_run++;
        if (stall_cycles !== 5 || stall_bad !== 0) begin
            tests_failed++; $display("FAIL t3_stall: got %0d stall cycles %0d bad, want 5 0", stall_cycles, stall_bad);
        end else $display("[TB] t3 stall held 5 cycles at idx 7");
        tests_run++;
        if (words_taken !== 1024 || obs_q.size() !== 1024 || timed_out !== 1'b0) begin
            tests_failed++; $display("FAIL t3_count: got words=%0d coefs=%0d, want 1024 1024", words_taken, obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            xfer_t e;
            e.val = 99999; e.idx = -1;
            if (i < exp_q.size()) e = exp_q[i];
            tests_run++;
            if (obs_q[i].val !== e.val || obs_q[i].idx !== e.idx) begin
                tests_failed++; $display("FAIL t3_coef[%0d]: got %0d@%0d, want %0d@%0d", i, obs_q[i].val, obs_q[i].idx, e.val, e.idx);
            end else $display("[TB] t3 xfer %0d coef=%0d idx=%0d", i, obs_q[i].val, obs_q[i].idx);
        end
        tests_run++;
        if (sqnorm !== 32'd692224 || done_cnt !== 1) begin
            tests_failed++; $display("FAIL t3_final: got sqnorm=%0d done=%0d, want 692224 1", sqnorm, done_cnt);
        end else $display("[TB] t3 sqnorm=%0d", sqnorm);
    endtask

    task automatic test_slow_rng();
        drive_run(1, 2, 50, -1, -1, 8000);
        tests_run++;
        if (words_taken !== 1024 || obs_q.size() !== 2 || timed_out !== 1'b0) begin
            tests_failed++; $display("FAIL t4_count: got words=%0d coefs=%0d, want 1024 2", words_taken, obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            xfer_t e;
            e.val = 99999; e.idx = -1;
            if (i < exp_q.size()) e = exp_q[i];
            tests_run++;
            if (obs_q[i].val !== e.val || obs_q[i].idx !== e.idx) begin
                tests_failed++; $display("FAIL t4_coef[%0d]: got %0d@%0d, want %0d@%0d", i, obs_q[i].val, obs_q[i].idx, e.val, e.idx);
            end else $display("[TB] t4 xfer %0d coef=%0d idx=%0d", i, obs_q[i].val, obs_q[i].idx);
        end
        tests_run++;
        if (sqnorm !== 32'd177471488 || done_cnt !== 1) begin
            tests_failed++; $display("FAIL t4_final: got sqnorm=%0d done=%0d, want 177471488 1", sqnorm, done_cnt);
        end else $display("[TB] t4 sqnorm=%0d", sqnorm);
    endtask

    task automatic test_table_bounds();
        drive_run(10, 3, 100, -1, 16, 200);
        tests_run++;
        if (obs_q.size() !== 16) begin
            tests_failed++; $display("FAIL tb_count: got %0d coefs, want 16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            xfer_t e;
            e.val = 99999; e.idx = -1;
            if (i < exp_q.size()) e = exp_q[i];
            tests_run++;
            if (obs_q[i].val !== e.val || obs_q[i].idx !== e.idx) begin
                tests_failed++; $display("FAIL table_coef[%0d]: got %0d@%0d, want %0d@%0d", i, obs_q[i].val, obs_q[i].idx, e.val, e.idx);
            end else $display("[TB] table xfer %0d coef=%0d idx=%0d", i, obs_q[i].val, obs_q[i].idx);
        end
        tests_run++;
        if (busy !== 1'b0 || coef_valid !== 1'b0 || rng_extract !== 1'b0 || done_cnt !== 0 || sqnorm !== 32'd2742) begin
            tests_failed++; $display("FAIL table_abort: got busy=%b cv=%b ext=%b done=%0d sq=%0d, want 0 0 0 0 2742",
                                     busy, coef_valid, rng_extract, done_cnt, sqnorm);
        end else $display("[TB] table run aborted cleanly, sqnorm=%0d", sqnorm);
    endtask

    task automatic test_abort_reset();
        drive_run(10, 0, 100, -1, 100, 1000);
        tests_run++;
        if (obs_q.size() !== 100 || busy !== 1'b0 || coef_valid !== 1'b0 || rng_extract !== 1'b0 || done_cnt !== 0 || sqnorm !== 32'd67600) begin
            tests_failed++; $display("FAIL t5_abort: got coefs=%0d busy=%b cv=%b ext=%b done=%0d sq=%0d, want 100 0 0 0 0 67600",
                                     obs_q.size(), busy, coef_valid, rng_extract, done_cnt, sqnorm);
        end else $display("[TB] t5 abort at idx 100 returned to idle");
        @(negedge clk); start = 1'b1; logn_in = 4'd10;
        rng = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; rng_valid = 1'b1; coef_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4 && !rng_extract; k++) @(negedge clk);
        tests_run++;
        if (rng_extract !== 1'b1) begin
            tests_failed++; $display("FAIL t5_in_acc: got rng_extract=%b, want 1", rng_extract);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, coef_valid, rng_extract, done, err} !== 5'b0 || coef !== '0 || coef_idx !== '0 || sqnorm !== '0) begin
            tests_failed++; $display("FAIL t5_reset_mid: got flags=%b coef=%0d idx=%0d sq=%0d, want all 0",
                                     {busy, coef_valid, rng_extract, done, err}, coef, coef_idx, sqnorm);
        end else $display("[TB] t5 reset mid-run cleared outputs");
        repeat (2) @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL t5_reset_hold: got done=%b busy=%b, want 0 0", done, busy);
        end
        rst_n = 1'b1; rng_valid = 1'b0; coef_ready = 1'b0;
        drive_run(8, 0, 100, -1, -1, 3000);
        tests_run++;
        if (obs_q.size() !== 256 || timed_out !== 1'b0) begin
            tests_failed++; $display("FAIL t5_rerun_count: got %0d coefs, want 256", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            xfer_t e;
            e.val = 99999; e.idx = -1;
            if (i < exp_q.size()) e = exp_q[i];
            tests_run++;
            if (obs_q[i].val !== e.val || obs_q[i].idx !== e.idx || e.val !== -104) begin
                tests_failed++; $display("FAIL t5_coef[%0d]: got %0d@%0d, want %0d@%0d (-104)", i, obs_q[i].val, obs_q[i].idx, e.val, e.idx);
            end else $display("[TB] t5 xfer %0d coef=%0d idx=%0d", i, obs_q[i].val, obs_q[i].idx);
        end
        tests_run++;
        if (sqnorm !== 32'd2768896 || done_cnt !== 1) begin
            tests_failed++; $display("FAIL t5_rerun_final: got sqnorm=%0d done=%0d, want 2768896 1", sqnorm, done_cnt);
        end else $display("[TB] t5 rerun sqnorm=%0d", sqnorm);
    endtask

    task automatic test_bad_logn();
        int bad [3];
        bad = '{0, 11, 15};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); start = 1'b1; logn_in = 4'(bad[i]);
            @(negedge clk); start = 1'b0;
            tests_run++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL t6_err_logn%0d: got err=%b busy=%b, want 1 0", bad[i], err, busy);
            end else $display("[TB] t6 logn=%0d err pulse", bad[i]);
            @(negedge clk);
            tests_run++;
            if (err !== 1'b0 || busy !== 1'b0 || sqnorm !== 32'd2768896) begin
                tests_failed++; $display("FAIL t6_after_logn%0d: got err=%b busy=%b sq=%0d, want 0 0 2768896", bad[i], err, busy, sqnorm);
            end
        end
        @(negedge clk); start = 1'b1; abort = 1'b1; logn_in = 4'd10;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            tests_failed++; $display("FAIL t6_start_abort: got busy=%b err=%b, want 0 0", busy, err);
        end else $display("[TB] t6 start with abort stays idle");
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_alt_pattern();
        test_backpressure();
        test_slow_rng();
        test_table_bounds();
        test_abort_reset();
        test_bad_logn();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no summary by time limit, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
